// File: rtl/decode_pkg.sv
// Shared decode constants and the ID/EX bundle type.
// Type bit positions, MIPS opcode/func encodings and Tnew codes.
package decode_pkg;

  localparam int NUM_TYPES_DEF = 60;

  localparam int T_ADDU  = 0;
  localparam int T_SUBU  = 1;
  localparam int T_ORI   = 2;
  localparam int T_LW    = 3;
  localparam int T_SW    = 4;
  localparam int T_BEQ   = 5;
  localparam int T_LUI   = 6;
  localparam int T_J     = 7;
  localparam int T_JAL   = 8;
  localparam int T_JR    = 9;
  localparam int T_SLL   = 10;
  localparam int T_ADDIU = 11;
  localparam int T_MULT  = 12;
  localparam int T_MULTU = 13;
  localparam int T_DIV   = 14;
  localparam int T_DIVU  = 15;
  localparam int T_MFHI  = 16;
  localparam int T_MFLO  = 17;
  localparam int T_MTHI  = 18;
  localparam int T_MTLO  = 19;
  localparam int T_KNOWN = 20;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUBU  = 6'h23;

  localparam logic [1:0] TNEW_NONE = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
    logic [1:0]  tnew;
  } id_ex_t;

endpackage

// File: rtl/instr_class.sv
// Combinational MIPS instruction classifier.
// Produces one-hot type, register fields, write-register and Tnew.
module instr_class import decode_pkg::*; #(
  parameter int NUM_TYPES      = NUM_TYPES_DEF,
  parameter int SUPPORT_MULDIV = 1
) (
  input  logic [31:0]          instr_i,
  output logic [NUM_TYPES-1:0] type_o,
  output logic [4:0]           rs_o,
  output logic [4:0]           rt_o,
  output logic [4:0]           wreg_o,
  output logic [1:0]           tnew_o,
  output logic                 md_o,
  output logic                 mult_o,
  output logic                 div_o
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rd;
  logic [T_KNOWN-1:0] known;
  logic err;
  logic wr_rd;
  logic wr_rt;
  logic unused_shamt;

  assign op = instr_i[31:26];
  assign fn = instr_i[5:0];
  assign rd = instr_i[15:11];
  assign rs_o = instr_i[25:21];
  assign rt_o = instr_i[20:16];
  assign unused_shamt = ^instr_i[10:6];

  always_comb begin
    known = '0;
    unique case (op)
      OP_RTYPE: begin
        unique case (fn)
          F_ADDU:  known[T_ADDU]  = 1'b1;
          F_SUBU:  known[T_SUBU]  = 1'b1;
          F_JR:    known[T_JR]    = 1'b1;
          F_SLL:   known[T_SLL]   = 1'b1;
          F_MULT:  known[T_MULT]  = 1'b1;
          F_MULTU: known[T_MULTU] = 1'b1;
          F_DIV:   known[T_DIV]   = 1'b1;
          F_DIVU:  known[T_DIVU]  = 1'b1;
          F_MFHI:  known[T_MFHI]  = 1'b1;
          F_MFLO:  known[T_MFLO]  = 1'b1;
          F_MTHI:  known[T_MTHI]  = 1'b1;
          F_MTLO:  known[T_MTLO]  = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:   known[T_ORI]   = 1'b1;
      OP_LW:    known[T_LW]    = 1'b1;
      OP_SW:    known[T_SW]    = 1'b1;
      OP_BEQ:   known[T_BEQ]   = 1'b1;
      OP_LUI:   known[T_LUI]   = 1'b1;
      OP_J:     known[T_J]     = 1'b1;
      OP_JAL:   known[T_JAL]   = 1'b1;
      OP_ADDIU: known[T_ADDIU] = 1'b1;
      default: ;
    endcase
    // Without the mult/div unit its encodings fall through to ERR
    if (SUPPORT_MULDIV == 0) known[T_MTLO:T_MULT] = '0;
  end

  assign err = ~|known;

  always_comb begin
    type_o = '0;
    type_o[T_KNOWN-1:0] = known;
    type_o[NUM_TYPES-1] = err;
  end

  assign wr_rd = known[T_ADDU] | known[T_SUBU] | known[T_SLL]
               | known[T_MFHI] | known[T_MFLO];
  assign wr_rt = known[T_ORI] | known[T_LW] | known[T_LUI]
               | known[T_ADDIU];

  always_comb begin
    wreg_o = '0;
    tnew_o = TNEW_NONE;
    if (wr_rd) begin
      wreg_o = rd;
      tnew_o = TNEW_ALU;
    end else if (wr_rt) begin
      wreg_o = rt_o;
      tnew_o = known[T_LW] ? TNEW_LOAD : TNEW_ALU;
    end else if (known[T_JAL]) begin
      wreg_o = REG_RA;
      tnew_o = TNEW_NONE;
    end
  end

  assign md_o   = |known[T_MTLO:T_MULT];
  assign mult_o = known[T_MULT] | known[T_MULTU];
  assign div_o  = known[T_DIV] | known[T_DIVU];

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: ID/EX register, valid/ready handshake,
// flush and mult/div busy scoreboard.
module decode_stage import decode_pkg::*; #(
  parameter int NUM_TYPES      = NUM_TYPES_DEF,
  parameter int SUPPORT_MULDIV = 1,
  parameter int MD_LAT_MULT    = 5,
  parameter int MD_LAT_DIV     = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_valid,
  input  logic [31:0]          if_instr,
  input  logic [31:0]          if_pc,
  output logic                 id_ready,
  input  logic                 ex_ready,
  input  logic                 flush,
  output logic                 ex_valid,
  output logic [31:0]          ex_pc,
  output logic [31:0]          ex_instr,
  output logic [NUM_TYPES-1:0] ex_type,
  output logic [4:0]           ex_rs,
  output logic [4:0]           ex_rt,
  output logic [4:0]           ex_wreg,
  output logic [1:0]           ex_tnew,
  output logic                 ex_err,
  output logic                 md_busy
);

  localparam int MD_MAX = (MD_LAT_MULT > MD_LAT_DIV) ? MD_LAT_MULT
                                                     : MD_LAT_DIV;
  localparam int CW = (MD_MAX < 1) ? 1 : $clog2(MD_MAX + 1);

  logic [NUM_TYPES-1:0] dec_type;
  logic [4:0] dec_rs;
  logic [4:0] dec_rt;
  logic [4:0] dec_wreg;
  logic [1:0] dec_tnew;
  logic dec_md;
  logic dec_mult;
  logic dec_div;

  id_ex_t ex_q, ex_d;
  logic [NUM_TYPES-1:0] type_q, type_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic md_stall;
  logic accept;

  instr_class #(
    .NUM_TYPES      (NUM_TYPES),
    .SUPPORT_MULDIV (SUPPORT_MULDIV)
  ) u_instr_class (
    .instr_i (if_instr),
    .type_o  (dec_type),
    .rs_o    (dec_rs),
    .rt_o    (dec_rt),
    .wreg_o  (dec_wreg),
    .tnew_o  (dec_tnew),
    .md_o    (dec_md),
    .mult_o  (dec_mult),
    .div_o   (dec_div)
  );

  assign md_busy  = (cnt_q != '0);
  assign md_stall = if_valid & dec_md & md_busy;
  assign id_ready = ex_ready & ~md_stall;
  // flush kills the load without feeding back into id_ready
  assign accept   = if_valid & id_ready & ~flush;

  always_comb begin
    ex_d   = ex_q;
    type_d = type_q;
    if (accept) begin
      ex_d.valid = 1'b1;
      ex_d.pc    = if_pc;
      ex_d.instr = if_instr;
      ex_d.rs    = dec_rs;
      ex_d.rt    = dec_rt;
      ex_d.wreg  = dec_wreg;
      ex_d.tnew  = dec_tnew;
      type_d     = dec_type;
    end else if (flush || ex_ready) begin
      ex_d   = '0;
      type_d = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (SUPPORT_MULDIV == 0) cnt_d = '0;
    else if (accept && dec_mult) cnt_d = CW'(MD_LAT_MULT);
    else if (accept && dec_div) cnt_d = CW'(MD_LAT_DIV);
    else if (md_busy) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q   <= '0;
      type_q <= '0;
      cnt_q  <= '0;
    end else begin
      ex_q   <= ex_d;
      type_q <= type_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ex_valid = ex_q.valid;
  assign ex_pc    = ex_q.pc;
  assign ex_instr = ex_q.instr;
  assign ex_type  = type_q;
  assign ex_rs    = ex_q.rs;
  assign ex_rt    = ex_q.rt;
  assign ex_wreg  = ex_q.wreg;
  assign ex_tnew  = ex_q.tnew;
  assign ex_err   = type_q[NUM_TYPES-1] & ex_q.valid;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps plus random traffic
// checked against a behavioural pipeline model.
module tb_decode_stage;

  localparam int NT = 60;
  localparam int ERR = NT - 1;

  logic clk = 1'b0;
  logic reset, if_valid, ex_ready, flush;
  logic [31:0] if_instr, if_pc;

  logic id_ready, ex_valid, ex_err, md_busy;
  logic [31:0] ex_pc, ex_instr;
  logic [NT-1:0] ex_type;
  logic [4:0] ex_rs, ex_rt, ex_wreg;
  logic [1:0] ex_tnew;

  logic id_ready_b, ex_valid_b, ex_err_b, md_busy_b;
  logic [31:0] ex_pc_b, ex_instr_b;
  logic [NT-1:0] ex_type_b;
  logic [4:0] ex_rs_b, ex_rt_b, ex_wreg_b;
  logic [1:0] ex_tnew_b;

  int passes = 0;
  int total = 0;
  bit last_rdy;

  always #5 clk = ~clk;

  decode_stage #(
    .NUM_TYPES(NT), .SUPPORT_MULDIV(1),
    .MD_LAT_MULT(5), .MD_LAT_DIV(10)
  ) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_type(ex_type),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
    .ex_tnew(ex_tnew), .ex_err(ex_err), .md_busy(md_busy)
  );

  decode_stage #(
    .NUM_TYPES(NT), .SUPPORT_MULDIV(0),
    .MD_LAT_MULT(5), .MD_LAT_DIV(10)
  ) dut_b (
    .clk(clk), .reset(reset), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready_b),
    .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid_b),
    .ex_pc(ex_pc_b), .ex_instr(ex_instr_b), .ex_type(ex_type_b),
    .ex_rs(ex_rs_b), .ex_rt(ex_rt_b), .ex_wreg(ex_wreg_b),
    .ex_tnew(ex_tnew_b), .ex_err(ex_err_b), .md_busy(md_busy_b)
  );

  typedef struct {
    bit          v;
    logic [31:0] pc;
    logic [31:0] instr;
    int          cls;
  } ent_t;

  ent_t m[2];
  int   cnt[2];

  // Class index from the instruction table; md selects mult/div support
  function automatic int cls_of(logic [31:0] w, bit md);
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h21: return 0;
        6'h23: return 1;
        6'h08: return 9;
        6'h00: return 10;
        6'h18: return md ? 12 : ERR;
        6'h19: return md ? 13 : ERR;
        6'h1a: return md ? 14 : ERR;
        6'h1b: return md ? 15 : ERR;
        6'h10: return md ? 16 : ERR;
        6'h12: return md ? 17 : ERR;
        6'h11: return md ? 18 : ERR;
        6'h13: return md ? 19 : ERR;
        default: return ERR;
      endcase
    end
    case (op)
      6'h0d: return 2;
      6'h23: return 3;
      6'h2b: return 4;
      6'h04: return 5;
      6'h0f: return 6;
      6'h02: return 7;
      6'h03: return 8;
      6'h09: return 11;
      default: return ERR;
    endcase
  endfunction

  function automatic logic [4:0] wreg_of(logic [31:0] w, int c);
    if (c inside {0, 1, 10, 16, 17}) return w[15:11];
    if (c inside {2, 3, 6, 11}) return w[20:16];
    if (c == 8) return 5'd31;
    return 5'd0;
  endfunction

  function automatic logic [1:0] tnew_of(int c);
    if (c == 3) return 2'd2;
    if (c inside {0, 1, 2, 6, 10, 11, 16, 17}) return 2'd1;
    return 2'd0;
  endfunction

  function automatic ent_t empty_ent();
    ent_t e;
    e.v = 1'b0;
    e.pc = '0;
    e.instr = '0;
    e.cls = 0;
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_outputs();
    ent_t e;
    logic [63:0] ty;
    e = m[0];
    ty = e.v ? (64'd1 << e.cls) : 64'd0;
    chk("ex_valid", 64'(ex_valid), 64'(e.v));
    chk("ex_pc", 64'(ex_pc), e.v ? 64'(e.pc) : 64'd0);
    chk("ex_instr", 64'(ex_instr), e.v ? 64'(e.instr) : 64'd0);
    chk("ex_type", 64'(ex_type), ty);
    chk("ex_rs", 64'(ex_rs), e.v ? 64'(e.instr[25:21]) : 64'd0);
    chk("ex_rt", 64'(ex_rt), e.v ? 64'(e.instr[20:16]) : 64'd0);
    chk("ex_wreg", 64'(ex_wreg),
        e.v ? 64'(wreg_of(e.instr, e.cls)) : 64'd0);
    chk("ex_tnew", 64'(ex_tnew), e.v ? 64'(tnew_of(e.cls)) : 64'd0);
    chk("ex_err", 64'(ex_err), 64'(e.v && e.cls == ERR));
    chk("md_busy", 64'(md_busy), 64'(cnt[0] != 0));
    e = m[1];
    ty = e.v ? (64'd1 << e.cls) : 64'd0;
    chk("b_ex_valid", 64'(ex_valid_b), 64'(e.v));
    chk("b_ex_type", 64'(ex_type_b), ty);
    chk("b_ex_wreg", 64'(ex_wreg_b),
        e.v ? 64'(wreg_of(e.instr, e.cls)) : 64'd0);
    chk("b_ex_err", 64'(ex_err_b), 64'(e.v && e.cls == ERR));
    chk("b_md_busy", 64'(md_busy_b), 64'(cnt[1] != 0));
  endtask

  // One clock: check id_ready before the edge, advance model, check after
  task automatic tick();
    ent_t nm[2];
    int nc[2];
    bit rdy;
    int c;
    #1;
    for (int k = 0; k < 2; k++) begin
      c = cls_of(if_instr, k == 0);
      rdy = ex_ready && !(if_valid && c >= 12 && c <= 19 && cnt[k] != 0);
      nc[k] = (cnt[k] > 0) ? cnt[k] - 1 : 0;
      if (if_valid && rdy && !flush) begin
        if (c == 12 || c == 13) nc[k] = 5;
        if (c == 14 || c == 15) nc[k] = 10;
      end
      if (reset) nc[k] = 0;
      if (reset || flush) nm[k] = empty_ent();
      else if (!ex_ready) nm[k] = m[k];
      else if (if_valid && rdy) nm[k] = '{1'b1, if_pc, if_instr, c};
      else nm[k] = empty_ent();
      if (k == 0) chk("id_ready", 64'(id_ready), 64'(rdy));
      else chk("b_id_ready", 64'(id_ready_b), 64'(rdy));
    end
    last_rdy = id_ready;
    @(posedge clk);
    m = nm;
    cnt = nc;
    #1;
    chk_outputs();
  endtask

  task automatic issue(logic [31:0] w, logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = w;
    if_pc = pc;
    tick();
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    int s;
    w = $urandom;
    s = $urandom_range(0, 23);
    if (s < 12) w[31:26] = 6'h00;
    case (s)
      0: w[5:0] = 6'h21;
      1: w[5:0] = 6'h23;
      2: w[5:0] = 6'h08;
      3: w[5:0] = 6'h00;
      4: w[5:0] = 6'h18;
      5: w[5:0] = 6'h19;
      6: w[5:0] = 6'h1a;
      7: w[5:0] = 6'h1b;
      8: w[5:0] = 6'h10;
      9: w[5:0] = 6'h12;
      10: w[5:0] = 6'h11;
      11: w[5:0] = 6'h13;
      12: w[31:26] = 6'h0d;
      13: w[31:26] = 6'h23;
      14: w[31:26] = 6'h2b;
      15: w[31:26] = 6'h04;
      16: w[31:26] = 6'h0f;
      17: w[31:26] = 6'h02;
      18: w[31:26] = 6'h03;
      19: w[31:26] = 6'h09;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    int stalls;
    m[0] = empty_ent();
    m[1] = empty_ent();
    cnt[0] = 0;
    cnt[1] = 0;
    reset = 1'b1;
    if_valid = 1'b0;
    if_instr = '0;
    if_pc = '0;
    ex_ready = 1'b1;
    flush = 1'b0;
    tick();
    ex_ready = 1'b0;
    tick();
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_busy", 64'(md_busy), 64'd0);
    reset = 1'b0;
    ex_ready = 1'b1;

    issue(32'h00221821, 32'h0000_1000);
    chk("addu_type", 64'(ex_type), 64'd1);
    chk("addu_wreg", 64'(ex_wreg), 64'd3);
    chk("addu_tnew", 64'(ex_tnew), 64'd1);

    issue(32'h8CC50004, 32'h0000_1004);
    chk("lw_wreg", 64'(ex_wreg), 64'd5);
    chk("lw_tnew", 64'(ex_tnew), 64'd2);
    issue(32'h0C000010, 32'h0000_1008);
    chk("jal_type", 64'(ex_type), 64'h100);
    chk("jal_wreg", 64'(ex_wreg), 64'd31);

    issue(32'h00220018, 32'h0000_100c);
    if_instr = 32'h00002012;
    if_pc = 32'h0000_1010;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_rdy) break;
      stalls++;
    end
    chk("mflo_stall", 64'(stalls), 64'd5);
    chk("mflo_wreg", 64'(ex_wreg), 64'd4);

    issue(32'h00220018, 32'h0000_1014);
    issue(32'h00221821, 32'h0000_1018);
    chk("addu_busy_pass", 64'(last_rdy), 64'd1);
    chk("addu_busy_md", 64'(md_busy), 64'd1);
    if_valid = 1'b0;
    repeat (12) tick();

    flush = 1'b1;
    issue(32'h0022001A, 32'h0000_1020);
    flush = 1'b0;
    if_valid = 1'b0;
    chk("flush_valid", 64'(ex_valid), 64'd0);
    chk("flush_busy", 64'(md_busy), 64'd0);

    issue(32'h00221821, 32'h0000_1100);
    ex_ready = 1'b0;
    if_instr = 32'h8CC50004;
    repeat (3) begin
      tick();
      chk("hold_ready", 64'(last_rdy), 64'd0);
    end
    reset = 1'b1;
    tick();
    chk("rst_mid_valid", 64'(ex_valid), 64'd0);
    reset = 1'b0;
    ex_ready = 1'b1;

    issue(32'hFC000000, 32'h0000_1200);
    chk("err_flag", 64'(ex_err), 64'd1);
    chk("err_wreg", 64'(ex_wreg), 64'd0);
    issue(32'h00220018, 32'h0000_1204);
    chk("b_mult_err", 64'(ex_err_b), 64'd1);
    chk("b_mult_busy", 64'(md_busy_b), 64'd0);
    chk("a_mult_busy", 64'(md_busy), 64'd1);

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 15) == 0);
      ex_ready = ($urandom_range(0, 4) != 0);
      if_valid = ($urandom_range(0, 3) != 0);
      if_instr = rnd_instr();
      if_pc = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
